// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory request/response plus the IF/ID presentation and redirect signals.
// The master modport belongs to fetch_unit; the slave modport belongs to the memory/decode side.
interface fetch_unit_if;
  logic        stallIf;
  logic        redirect;
  logic [15:0] redirectPc;
  logic        imemReq;
  logic [15:0] imemAddr;
  logic [15:0] imemRdata;
  logic        imemDone;
  logic [15:0] pcOut;
  logic [15:0] instrOut;
  logic        validInsOut;
  logic        flushIf;
  logic        RsValidOut;
  logic        RtValidOut;
  logic        writeRegValidOut;
  logic        halted;

  modport master (
    input  stallIf, redirect, redirectPc, imemRdata, imemDone,
    output imemReq, imemAddr, pcOut, instrOut, validInsOut, flushIf,
           RsValidOut, RtValidOut, writeRegValidOut, halted
  );

  modport slave (
    output stallIf, redirect, redirectPc, imemRdata, imemDone,
    input  imemReq, imemAddr, pcOut, instrOut, validInsOut, flushIf,
           RsValidOut, RtValidOut, writeRegValidOut, halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, presents data the cycle imemDone fires, one-entry hold buffer
// when stallIf backpressures; redirects squash. FETCH_PREDECODE_EN enables operand-flag predecode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic           clk,
  input logic           rst,
  fetch_unit_if.master  fu
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    HOLD = 2'd1,
    DROP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] reqAddr;
  logic [15:0] bufInstr;

  logic        present;
  logic        consume;
  logic        isHalt;
  logic [15:0] instr;
  logic [4:0]  opcode;

  // Outputs that matter to the pipeline are held low while reset is asserted.
  assign present = (state == REQ && fu.imemDone) || (state == HOLD);
  assign instr   = (state == HOLD) ? bufInstr : fu.imemRdata;
  assign opcode  = instr[15:11];
  assign isHalt  = (opcode == 5'b00000);
  assign consume = fu.validInsOut && !fu.stallIf;

  assign fu.validInsOut = rst && !fu.redirect && present;
  assign fu.flushIf     = rst && fu.redirect;
  assign fu.halted      = rst && (state == HALT);
  assign fu.imemReq     = (state == REQ) || (state == DROP);
  assign fu.imemAddr    = (state == DROP) ? reqAddr : pc;
  assign fu.instrOut    = instr;
  assign fu.pcOut       = pc + 16'd2;

`ifdef FETCH_PREDECODE_EN
  always_comb begin
    fu.RsValidOut = 1'b1;
    unique casez (opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b00110, 5'b11000: fu.RsValidOut = 1'b0;
      default:            fu.RsValidOut = 1'b1;
    endcase
  end

  always_comb begin
    fu.RtValidOut = 1'b0;
    unique casez (opcode)
      5'b10000, 5'b10011, 5'b11010, 5'b11011,
      5'b111??: fu.RtValidOut = 1'b1;
      default:  fu.RtValidOut = 1'b0;
    endcase
  end

  always_comb begin
    fu.writeRegValidOut = 1'b1;
    unique casez (opcode)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101,
      5'b011??, 5'b10000: fu.writeRegValidOut = 1'b0;
      default:            fu.writeRegValidOut = 1'b1;
    endcase
  end
`else
  // Conservative: hazard logic assumes every operand is live.
  assign fu.RsValidOut       = 1'b1;
  assign fu.RtValidOut       = 1'b1;
  assign fu.writeRegValidOut = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      reqAddr  <= 16'h0000;
      bufInstr <= 16'h0000;
    end else if (fu.redirect) begin
      pc <= fu.redirectPc;
      unique case (state)
        REQ: begin
          // An in-flight request must still complete; remember its address and discard its data.
          if (!fu.imemDone) begin
            state   <= DROP;
            reqAddr <= pc;
          end else begin
            state <= REQ;
          end
        end
        DROP:    if (fu.imemDone) state <= REQ;
        default: state <= REQ;
      endcase
    end else begin
      unique case (state)
        REQ: begin
          if (fu.imemDone) begin
            if (fu.stallIf) begin
              bufInstr <= fu.imemRdata;
              state    <= HOLD;
            end else begin
              pc    <= pc + 16'd2;
              state <= isHalt ? HALT : REQ;
            end
          end
        end
        HOLD: begin
          if (consume) begin
            pc    <= pc + 16'd2;
            state <= isHalt ? HALT : REQ;
          end
        end
        DROP:    if (fu.imemDone) state <= REQ;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change 1 time unit after each rising edge, outputs are checked 1 unit later.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   nTests = 0;
  int   nFail  = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .fu  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    bus.stallIf    = 1'b0;
    bus.redirect   = 1'b0;
    bus.redirectPc = 16'h0000;
    bus.imemRdata  = 16'h0000;
    bus.imemDone   = 1'b0;

    // Reset
    tick; tick;
    bus.redirect = 1'b1; bus.imemDone = 1'b1; settle;
    check("rst_valid",   {15'd0, bus.validInsOut}, 16'd0);
    check("rst_flush",   {15'd0, bus.flushIf},     16'd0);
    check("rst_halted",  {15'd0, bus.halted},      16'd0);
    tick;
    bus.redirect = 1'b0; bus.imemDone = 1'b0;
    rst = 1'b1; settle;
    check("first_req",   {15'd0, bus.imemReq},     16'd1);
    check("first_addr",  bus.imemAddr,             16'h0000);
    check("first_valid", {15'd0, bus.validInsOut}, 16'd0);

    // Back-to-back fetch
    bus.imemDone = 1'b1; bus.imemRdata = 16'h4001; settle;
    check("f0_addr",  bus.imemAddr,             16'h0000);
    check("f0_pc",    bus.pcOut,                16'h0002);
    check("f0_valid", {15'd0, bus.validInsOut}, 16'd1);
    check("f0_instr", bus.instrOut,             16'h4001);
    tick;
    bus.imemRdata = 16'h4002; settle;
    check("f1_addr",  bus.imemAddr,             16'h0002);
    check("f1_pc",    bus.pcOut,                16'h0004);
    check("f1_valid", {15'd0, bus.validInsOut}, 16'd1);
    tick;

    // Stall holds the fetched word
    bus.imemRdata = 16'hD8A4; bus.stallIf = 1'b1; settle;
    check("st_addr",  bus.imemAddr,             16'h0004);
    check("st_valid", {15'd0, bus.validInsOut}, 16'd1);
    tick;
    bus.imemDone = 1'b0; bus.imemRdata = 16'hFFFF; settle;
    check("hold_req",   {15'd0, bus.imemReq},     16'd0);
    check("hold_instr", bus.instrOut,             16'hD8A4);
    check("hold_valid", {15'd0, bus.validInsOut}, 16'd1);
    check("hold_pc",    bus.pcOut,                16'h0006);
    tick;
    check("hold2_instr", bus.instrOut, 16'hD8A4);
    check("hold2_pc",    bus.pcOut,    16'h0006);
    bus.stallIf = 1'b0; settle;
    check("rel_valid", {15'd0, bus.validInsOut}, 16'd1);
    tick;
    check("rel_req",  {15'd0, bus.imemReq}, 16'd1);
    check("rel_addr", bus.imemAddr,         16'h0006);

    // Redirect while request pending -> DROP
    bus.redirect = 1'b1; bus.redirectPc = 16'h0100; settle;
    check("rd_flush", {15'd0, bus.flushIf},     16'd1);
    check("rd_valid", {15'd0, bus.validInsOut}, 16'd0);
    tick;
    bus.redirect = 1'b0; settle;
    check("drop_req",  {15'd0, bus.imemReq}, 16'd1);
    check("drop_addr", bus.imemAddr,         16'h0006);
    bus.imemDone = 1'b1; bus.imemRdata = 16'h4444; settle;
    check("drop_valid", {15'd0, bus.validInsOut}, 16'd0);
    tick;
    bus.imemDone = 1'b0; settle;
    check("post_drop_addr", bus.imemAddr, 16'h0100);

    // HALT then redirect out of it
    bus.redirect = 1'b1; bus.redirectPc = 16'h0010; bus.imemDone = 1'b1; bus.imemRdata = 16'h1234; settle;
    check("rd2_valid", {15'd0, bus.validInsOut}, 16'd0);
    tick;
    bus.redirect = 1'b0; bus.imemRdata = 16'h0000; settle;
    check("halt_addr",  bus.imemAddr,             16'h0010);
    check("halt_valid", {15'd0, bus.validInsOut}, 16'd1);
    tick;
    bus.imemDone = 1'b0; settle;
    check("halted",     {15'd0, bus.halted},      16'd1);
    check("halt_req",   {15'd0, bus.imemReq},     16'd0);
    check("halt_novld", {15'd0, bus.validInsOut}, 16'd0);
    tick;
    check("halted2", {15'd0, bus.halted}, 16'd1);
    bus.redirect = 1'b1; bus.redirectPc = 16'h0020; settle;
    check("unhalt_flush", {15'd0, bus.flushIf}, 16'd1);
    tick;
    bus.redirect = 1'b0; settle;
    check("unhalt",      {15'd0, bus.halted},  16'd0);
    check("unhalt_addr", bus.imemAddr,         16'h0020);
    check("unhalt_req",  {15'd0, bus.imemReq}, 16'd1);

    // PC wrap
    bus.redirect = 1'b1; bus.redirectPc = 16'hFFFE; bus.imemDone = 1'b1; settle;
    tick;
    bus.redirect = 1'b0; bus.imemRdata = 16'h4001; settle;
    check("wrap_addr", bus.imemAddr, 16'hFFFE);
    check("wrap_pc",   bus.pcOut,    16'h0000);
    tick;
    bus.imemDone = 1'b0; settle;
    check("wrap_next", bus.imemAddr, 16'h0000);

    // Reset in the middle of DROP
    bus.redirect = 1'b1; bus.redirectPc = 16'h0050; bus.imemDone = 1'b1; settle;
    tick;
    bus.imemDone = 1'b0; bus.redirectPc = 16'h0300; settle;
    tick;
    bus.redirect = 1'b0; settle;
    check("drop2_addr", bus.imemAddr, 16'h0050);
    rst = 1'b0; bus.redirect = 1'b1; bus.redirectPc = 16'h0700; bus.imemDone = 1'b1; bus.imemRdata = 16'h0000; settle;
    check("rst2_valid", {15'd0, bus.validInsOut}, 16'd0);
    check("rst2_flush", {15'd0, bus.flushIf},     16'd0);
    tick;
    rst = 1'b1; bus.redirect = 1'b0; bus.imemDone = 1'b0; settle;
    check("rst2_addr", bus.imemAddr,             16'h0000);
    check("rst2_req",  {15'd0, bus.imemReq},     16'd1);
    check("rst2_halt", {15'd0, bus.halted},      16'd0);
    bus.imemDone = 1'b1; bus.imemRdata = 16'h4003; settle;
    check("late_valid", {15'd0, bus.validInsOut}, 16'd1);
    check("late_instr", bus.instrOut,             16'h4003);
    check("late_pc",    bus.pcOut,                16'h0002);
    tick;

    // Operand-use flags
    bus.imemRdata = 16'hC123; settle;
`ifdef FETCH_PREDECODE_EN
    check("lbi_rs", {15'd0, bus.RsValidOut},       16'd0);
    check("lbi_rt", {15'd0, bus.RtValidOut},       16'd0);
    check("lbi_wr", {15'd0, bus.writeRegValidOut}, 16'd1);
    tick;
    bus.imemRdata = 16'h8000; settle;
    check("st_rs", {15'd0, bus.RsValidOut},       16'd1);
    check("st_rt", {15'd0, bus.RtValidOut},       16'd1);
    check("st_wr", {15'd0, bus.writeRegValidOut}, 16'd0);
`else
    check("flag_rs", {15'd0, bus.RsValidOut},       16'd1);
    check("flag_rt", {15'd0, bus.RtValidOut},       16'd1);
    check("flag_wr", {15'd0, bus.writeRegValidOut}, 16'd1);
`endif
    tick;
    bus.imemDone = 1'b0;

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL be the PC loaded on reset.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset; synchronous, active-low.
REQ-004 stallIf  in  1  downstream IF/ID write disabled; the presented instruction is not consumed this cycle.
REQ-005 redirect  in  1  taken branch/jump from a later stage; redirectPc  in  16  target PC.
REQ-006 imemReq  out  1  memory request; imemAddr  out  16  fetch address.
REQ-007 imemRdata  in  16  fetched word; imemDone  in  1  completion, valid one cycle.
REQ-008 pcOut  out  16  PC+2 of the presented instruction; instrOut  out  16  presented instruction.
REQ-009 validInsOut  out  1  instrOut valid; flushIf  out  1  squash IF/ID entry.
REQ-010 RsValidOut, RtValidOut, writeRegValidOut  out  1 each  operand-use flags for the presented instruction.
REQ-011 halted  out  1  fetch stopped on HALT.

Function
REQ-012 States SHALL be REQ, HOLD, DROP and HALT, with registers pc[15:0], reqAddr[15:0], bufInstr[15:0].
REQ-013 REQ SHALL drive imemReq=1 and imemAddr=pc, holding both stable until imemDone.
REQ-014 In REQ with imemDone=1, the unit SHALL present imemRdata combinationally, with validInsOut=1, instrOut=imemRdata and pcOut=pc+2.
REQ-015 An instruction is consumed when validInsOut=1 and stallIf=0; pc SHALL then become pc+2, wrapping modulo 2^16.
REQ-016 In REQ with imemDone=1 and stallIf=1, imemRdata SHALL be captured into bufInstr and the state SHALL become HOLD.
REQ-017 HOLD SHALL drive imemReq=0, validInsOut=1 and instrOut=bufInstr; on stallIf=0 it SHALL consume the buffer and return to REQ.
REQ-018 A consumed instruction with instr[15:11]=5'b00000 (HALT) SHALL move the state to HALT, where imemReq=0, validInsOut=0 and halted=1.
REQ-019 redirect SHALL take priority over stallIf and imemDone: flushIf=redirect combinationally, validInsOut forced to 0, buffer discarded, and pc<=redirectPc.
REQ-020 If redirect occurs in REQ with imemDone=0, the state SHALL become DROP with reqAddr<=old pc; otherwise the state SHALL become REQ, including from HOLD and HALT, where halted clears.
REQ-021 DROP SHALL keep imemReq=1 and imemAddr=reqAddr until imemDone, discard that data, then go to REQ; a further redirect in DROP SHALL update pc only.
REQ-022 stallIf SHALL be ignored whenever validInsOut=0.

Reset
REQ-023 When rst=0 at a clock edge, the unit SHALL set state=REQ, pc=RESET_PC, reqAddr=0 and bufInstr=0.
REQ-024 Reset SHALL override redirect and any outstanding memory transaction; a completion arriving after reset SHALL be treated as the first fetch.
REQ-025 During reset and the first REQ cycle, validInsOut, flushIf and halted SHALL be 0.

Configuration
REQ-026 With FETCH_PREDECODE_EN defined, the operand flags SHALL be decoded from instrOut[15:11]:
  - RsValidOut=0 for 00000-00100, 00110 and 11000;
  - RtValidOut=1 only for 10000, 10011, 11010, 11011 and 111xx;
  - writeRegValidOut=0 for 00000-00101, 011xx and 10000.
REQ-027 Without FETCH_PREDECODE_EN, all three flags SHALL be tied to 1'b1 (conservative hazard detection), with no decode logic present.

Verification
REQ-028 Reset then imemDone every cycle with words 16'h4001, 16'h4002 -> imemAddr 0000, 0002; pcOut 0002, 0004; validInsOut=1 on each done cycle.
REQ-029 stallIf=1 for 3 cycles while imemDone brings 16'hD8A4 -> HOLD, instrOut stays D8A4, imemReq=0, pc unchanged; stallIf=0 -> consumed, next imemAddr=pc+2.
REQ-030 redirect=1 with redirectPc=16'h0100 while REQ waits -> flushIf=1 that cycle, DROP, old-address data discarded, next request address 0100.
REQ-031 Fetch 16'h0000 at pc=0010 with stallIf=0 -> halted=1, imemReq=0; then redirect to 0020 -> halted=0, imemAddr=0020.
REQ-032 pc=FFFE consumed -> pc wraps to 0000; rst=0 mid-DROP -> next cycle REQ with imemAddr=RESET_PC; with FETCH_PREDECODE_EN defined, instr 16'hC123 (LBI) -> RsValidOut=0, RtValidOut=0, writeRegValidOut=1.
